// File: rtl/pma_region_pkg.sv
// Shared types for the physical-memory-attribute region table.
package pma_region_pkg;

  localparam int MaxRules = 16;

  typedef enum logic [1:0] {
    FIELD_BASE   = 2'd0,
    FIELD_LENGTH = 2'd1,
    FIELD_ATTR   = 2'd2,
    FIELD_RSVD   = 2'd3
  } cfg_field_e;

  typedef struct packed {
    logic lock;
    logic cached;
    logic exec;
    logic nonidem;
  } pma_attr_t;

endpackage

// File: rtl/pma_region_table_if.sv
// Config request/response port plus lookup port of the PMA region table.
interface pma_region_table_if #(
  parameter int AddrWidth = 64,
  parameter int IdxW      = 2
);
  logic                 cfg_req_i;
  logic                 cfg_gnt_o;
  logic                 cfg_we_i;
  logic [IdxW-1:0]      cfg_idx_i;
  logic [1:0]           cfg_field_i;
  logic [AddrWidth-1:0] cfg_wdata_i;
  logic                 cfg_rvalid_o;
  logic [AddrWidth-1:0] cfg_rdata_o;
  logic                 cfg_err_o;
  logic                 lkp_valid_i;
  logic [AddrWidth-1:0] lkp_addr_i;
  logic                 lkp_valid_o;
  logic                 lkp_hit_o;
  logic [IdxW-1:0]      lkp_idx_o;
  logic [2:0]           lkp_attr_o;
  logic                 lkp_multi_o;

  modport master (
    output cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i, lkp_valid_i, lkp_addr_i,
    input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
           lkp_valid_o, lkp_hit_o, lkp_idx_o, lkp_attr_o, lkp_multi_o
  );

  modport slave (
    input  cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i, lkp_valid_i, lkp_addr_i,
    output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
           lkp_valid_o, lkp_hit_o, lkp_idx_o, lkp_attr_o, lkp_multi_o
  );
endinterface

// File: rtl/pma_region_match.sv
// Single-rule range comparator: base <= addr < base+length, no wraparound.
module pma_region_match #(
  parameter int AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] base,
  input  logic [AddrWidth-1:0] length,
  input  logic [AddrWidth-1:0] addr,
  output logic                 match
);
  // One extra bit so a region ending past 2^AddrWidth covers the top of the space.
  logic [AddrWidth:0] limit;

  assign limit = {1'b0, base} + {1'b0, length};
  assign match = (length != '0) && (addr >= base) && ({1'b0, addr} < limit);
endmodule

// File: rtl/pma_region_table.sv
// Runtime-programmable PMA table: lockable rules, config port, registered lookup.
module pma_region_table
  import pma_region_pkg::*;
#(
  parameter int                           NrRules     = 4,
  parameter int                           AddrWidth   = 64,
  parameter logic [NrRules*AddrWidth-1:0] RstBase     = '0,
  parameter logic [NrRules*AddrWidth-1:0] RstLength   = '0,
  parameter logic [NrRules*4-1:0]         RstAttr     = '0,
  parameter logic [2:0]                   DefaultAttr = 3'b000
) (
  input logic               clk_i,
  input logic               rst_i,
  pma_region_table_if.slave bus
);
  localparam int IdxW = (NrRules > 1) ? $clog2(NrRules) : 1;

  logic [NrRules-1:0][AddrWidth-1:0] base_q, len_q;
  pma_attr_t [NrRules-1:0]           attr_q;
  logic [NrRules-1:0]                match;

  logic                 rvalid_q, err_q;
  logic [AddrWidth-1:0] rdata_q;
  logic                 lvalid_q, lhit_q, lmulti_q;
  logic [IdxW-1:0]      lidx_q;
  logic [2:0]           lattr_q;

  cfg_field_e           field;
  logic                 idx_ok, cfg_err;
  logic [IdxW-1:0]      sel;
  logic [AddrWidth-1:0] rd_val;

  assign field  = cfg_field_e'(bus.cfg_field_i);
  assign idx_ok = (32'(bus.cfg_idx_i) < NrRules);
  assign sel    = idx_ok ? bus.cfg_idx_i : '0;

  always_comb begin
    cfg_err = 1'b0;
    rd_val  = '0;
    if (!idx_ok || field == FIELD_RSVD) cfg_err = 1'b1;
    else if (bus.cfg_we_i && attr_q[sel].lock) cfg_err = 1'b1;
    else begin
      case (field)
        FIELD_BASE:   rd_val = base_q[sel];
        FIELD_LENGTH: rd_val = len_q[sel];
        FIELD_ATTR:   rd_val = AddrWidth'(attr_q[sel]);
        default:      rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrRules; i++) begin
        base_q[i] <= RstBase[i*AddrWidth +: AddrWidth];
        len_q[i]  <= RstLength[i*AddrWidth +: AddrWidth];
        attr_q[i] <= pma_attr_t'(RstAttr[i*4 +: 4]);
      end
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= bus.cfg_req_i;
      err_q    <= bus.cfg_req_i && cfg_err;
      rdata_q  <= (bus.cfg_req_i && !bus.cfg_we_i && !cfg_err) ? rd_val : '0;
      // An unlocked rule may take its own lock bit in this write; lock never clears here.
      if (bus.cfg_req_i && bus.cfg_we_i && !cfg_err) begin
        case (field)
          FIELD_BASE:   base_q[sel] <= bus.cfg_wdata_i;
          FIELD_LENGTH: len_q[sel]  <= bus.cfg_wdata_i;
          FIELD_ATTR:   attr_q[sel] <= pma_attr_t'(bus.cfg_wdata_i[3:0]);
          default:      ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NrRules; g++) begin : g_match
    pma_region_match #(.AddrWidth(AddrWidth)) u_match (
      .base   (base_q[g]),
      .length (len_q[g]),
      .addr   (bus.lkp_addr_i),
      .match  (match[g])
    );
  end

  logic            hit_c, multi_c;
  logic [IdxW-1:0] idx_c;
  logic [2:0]      attr_c;

  always_comb begin
    hit_c  = 1'b0;
    idx_c  = '0;
    attr_c = DefaultAttr;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_c  = 1'b1;
        idx_c  = IdxW'(i);
        attr_c = {attr_q[i].cached, attr_q[i].exec, attr_q[i].nonidem};
      end
    end
    multi_c = ($countones(match) > 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lvalid_q <= 1'b0;
      lhit_q   <= 1'b0;
      lidx_q   <= '0;
      lattr_q  <= '0;
      lmulti_q <= 1'b0;
    end else begin
      lvalid_q <= bus.lkp_valid_i;
      if (bus.lkp_valid_i) begin
        lhit_q   <= hit_c;
        lidx_q   <= idx_c;
        lattr_q  <= attr_c;
        lmulti_q <= multi_c;
      end
    end
  end

  assign bus.cfg_gnt_o    = !rst_i;
  assign bus.cfg_rvalid_o = rvalid_q;
  assign bus.cfg_rdata_o  = rdata_q;
  assign bus.cfg_err_o    = err_q;
  assign bus.lkp_valid_o  = lvalid_q;
  assign bus.lkp_hit_o    = lhit_q;
  assign bus.lkp_idx_o    = lidx_q;
  assign bus.lkp_attr_o   = lattr_q;
  assign bus.lkp_multi_o  = lmulti_q;
endmodule

// File: tb/tb_pma_region_table.sv
// Directed bench for pma_region_table: reset map, programming, lock, overlap, top of space, errors.
module tb_pma_region_table;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pma_region_table_if #(.AddrWidth(64), .IdxW(2)) bus ();
  pma_region_table_if #(.AddrWidth(64), .IdxW(2)) bus2 ();

  pma_region_table #(
    .NrRules     (4),
    .AddrWidth   (64),
    .RstBase     ({64'h0, 64'h2000_0000, 64'h0, 64'h8000_0000}),
    .RstLength   ({64'h0, 64'h0000_1000, 64'h0, 64'h4000_0000}),
    .RstAttr     (16'h0106),
    .DefaultAttr (3'b001)
  ) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  // Non-power-of-two table so an out-of-range index is encodable.
  pma_region_table #(
    .NrRules     (3),
    .AddrWidth   (64),
    .RstBase     ({64'h0, 64'h0, 64'h0}),
    .RstLength   ({64'h55, 64'h0, 64'h0}),
    .RstAttr     (12'h0),
    .DefaultAttr (3'b000)
  ) dut3 (.clk_i(clk), .rst_i(rst), .bus(bus2.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input string tag, input logic we, input logic [1:0] idx, input logic [1:0] fld,
                     input logic [63:0] wd, input logic exp_err, input logic [63:0] exp_rd);
    bus.cfg_req_i   = 1'b1;
    bus.cfg_we_i    = we;
    bus.cfg_idx_i   = idx;
    bus.cfg_field_i = fld;
    bus.cfg_wdata_i = wd;
    tick();
    bus.cfg_req_i = 1'b0;
    bus.cfg_we_i  = 1'b0;
    chk({tag, ".rvalid"}, 64'(bus.cfg_rvalid_o), 64'd1);
    chk({tag, ".err"},    64'(bus.cfg_err_o),    64'(exp_err));
    chk({tag, ".rdata"},  bus.cfg_rdata_o,       exp_rd);
  endtask

  task automatic lkp(input string tag, input logic [63:0] a, input logic eh, input logic [1:0] ei,
                     input logic [2:0] ea, input logic em);
    bus.lkp_valid_i = 1'b1;
    bus.lkp_addr_i  = a;
    tick();
    bus.lkp_valid_i = 1'b0;
    chk({tag, ".valid"}, 64'(bus.lkp_valid_o), 64'd1);
    chk({tag, ".hit"},   64'(bus.lkp_hit_o),   64'(eh));
    chk({tag, ".idx"},   64'(bus.lkp_idx_o),   64'(ei));
    chk({tag, ".attr"},  64'(bus.lkp_attr_o),  64'(ea));
    chk({tag, ".multi"}, 64'(bus.lkp_multi_o), 64'(em));
  endtask

  initial begin
    bus.cfg_req_i = 0; bus.cfg_we_i = 0; bus.cfg_idx_i = 0; bus.cfg_field_i = 0;
    bus.cfg_wdata_i = 0; bus.lkp_valid_i = 0; bus.lkp_addr_i = 0;
    bus2.cfg_req_i = 0; bus2.cfg_we_i = 0; bus2.cfg_idx_i = 0; bus2.cfg_field_i = 0;
    bus2.cfg_wdata_i = 0; bus2.lkp_valid_i = 0; bus2.lkp_addr_i = 0;

    // Reset state, including a lookup presented while reset is high
    tick();
    bus.lkp_valid_i = 1'b1;
    bus.lkp_addr_i  = 64'h8000_1000;
    bus.cfg_req_i   = 1'b1;
    tick();
    chk("rst.gnt",    64'(bus.cfg_gnt_o),    64'd0);
    chk("rst.lvalid", 64'(bus.lkp_valid_o),  64'd0);
    chk("rst.hit",    64'(bus.lkp_hit_o),    64'd0);
    chk("rst.attr",   64'(bus.lkp_attr_o),   64'd0);
    chk("rst.rvalid", 64'(bus.cfg_rvalid_o), 64'd0);
    bus.lkp_valid_i = 1'b0;
    bus.cfg_req_i   = 1'b0;
    rst = 1'b0;
    #1;
    chk("gnt", 64'(bus.cfg_gnt_o), 64'd1);

    lkp("rst_hit", 64'h8000_1000, 1, 2'd0, 3'b110, 0);
    tick();
    chk("hold.valid", 64'(bus.lkp_valid_o), 64'd0);
    chk("hold.hit",   64'(bus.lkp_hit_o),   64'd1);
    lkp("excl_end", 64'hC000_0000, 0, 2'd0, 3'b001, 0);

    // Program rule 1
    cfg("w1.base", 1, 2'd1, 2'd0, 64'h1_0000, 0, 64'h0);
    tick();
    chk("rvalid_pulse", 64'(bus.cfg_rvalid_o), 64'd0);
    cfg("w1.len",  1, 2'd1, 2'd1, 64'h1_0000, 0, 64'h0);
    cfg("w1.attr", 1, 2'd1, 2'd2, 64'h2, 0, 64'h0);
    lkp("r1_top", 64'h1_FFFF, 1, 2'd1, 3'b010, 0);
    lkp("r1_end", 64'h2_0000, 0, 2'd0, 3'b001, 0);
    cfg("r1.len",  0, 2'd1, 2'd1, 64'h0, 0, 64'h1_0000);
    cfg("r1.attr", 0, 2'd1, 2'd2, 64'h0, 0, 64'h2);

    // Lock rule 2
    cfg("w2.lock",   1, 2'd2, 2'd2, 64'h9, 0, 64'h0);
    cfg("w2.locked", 1, 2'd2, 2'd0, 64'h1234, 1, 64'h0);
    cfg("r2.base",   0, 2'd2, 2'd0, 64'h0, 0, 64'h2000_0000);
    cfg("r2.attr",   0, 2'd2, 2'd2, 64'h0, 0, 64'h9);
    lkp("r2_hit", 64'h2000_0800, 1, 2'd2, 3'b001, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cfg("rr2.attr",  0, 2'd2, 2'd2, 64'h0, 0, 64'h1);
    cfg("rr2.base",  0, 2'd2, 2'd0, 64'h0, 0, 64'h2000_0000);
    cfg("rr1.len",   0, 2'd1, 2'd1, 64'h0, 0, 64'h0);
    cfg("w2.unlock", 1, 2'd2, 2'd0, 64'h3000_0000, 0, 64'h0);

    // Overlap with rule 0
    cfg("ov.base", 1, 2'd1, 2'd0, 64'h8000_0000, 0, 64'h0);
    cfg("ov.len",  1, 2'd1, 2'd1, 64'h1_0000, 0, 64'h0);
    cfg("ov.attr", 1, 2'd1, 2'd2, 64'h1, 0, 64'h0);
    lkp("overlap", 64'h8000_0010, 1, 2'd0, 3'b110, 1);
    lkp("single",  64'h8001_0000, 1, 2'd0, 3'b110, 0);

    // Top of address space
    cfg("top.base", 1, 2'd3, 2'd0, 64'hFFFF_FFFF_FFFF_F000, 0, 64'h0);
    cfg("top.len",  1, 2'd3, 2'd1, 64'h2000, 0, 64'h0);
    cfg("top.attr", 1, 2'd3, 2'd2, 64'h4, 0, 64'h0);
    lkp("top_hit", 64'hFFFF_FFFF_FFFF_FFFF, 1, 2'd3, 3'b100, 0);
    lkp("no_wrap", 64'h0, 0, 2'd0, 3'b001, 0);

    // Same-cycle write and lookup
    cfg("sc.base", 1, 2'd1, 2'd0, 64'h1_0000, 0, 64'h0);
    cfg("sc.attr", 1, 2'd1, 2'd2, 64'h2, 0, 64'h0);
    bus.cfg_req_i = 1; bus.cfg_we_i = 1; bus.cfg_idx_i = 2'd1; bus.cfg_field_i = 2'd0;
    bus.cfg_wdata_i = 64'h0;
    bus.lkp_valid_i = 1; bus.lkp_addr_i = 64'h1_0000;
    tick();
    bus.cfg_req_i = 0; bus.cfg_we_i = 0; bus.lkp_valid_i = 0;
    chk("sc.err", 64'(bus.cfg_err_o), 64'd0);
    chk("sc.hit", 64'(bus.lkp_hit_o), 64'd1);
    chk("sc.idx", 64'(bus.lkp_idx_o), 64'd1);
    lkp("sc_after", 64'h1_0000, 0, 2'd0, 3'b001, 0);

    // Reserved field, back-to-back reads
    cfg("rsvd.rd", 0, 2'd0, 2'd3, 64'h0, 1, 64'h0);
    cfg("rsvd.wr", 1, 2'd0, 2'd3, 64'h77, 1, 64'h0);
    bus.cfg_req_i = 1; bus.cfg_we_i = 0; bus.cfg_idx_i = 2'd0; bus.cfg_field_i = 2'd0;
    tick();
    chk("b2b0.rvalid", 64'(bus.cfg_rvalid_o), 64'd1);
    chk("b2b0.rdata",  bus.cfg_rdata_o, 64'h8000_0000);
    bus.cfg_field_i = 2'd1;
    tick();
    bus.cfg_req_i = 0;
    chk("b2b1.rvalid", 64'(bus.cfg_rvalid_o), 64'd1);
    chk("b2b1.rdata",  bus.cfg_rdata_o, 64'h4000_0000);
    tick();
    chk("b2b.idle", 64'(bus.cfg_rvalid_o), 64'd0);

    // Index beyond a 3-rule table
    bus2.cfg_req_i = 1; bus2.cfg_we_i = 0; bus2.cfg_idx_i = 2'd3; bus2.cfg_field_i = 2'd1;
    tick();
    chk("oob.rd.err",   64'(bus2.cfg_err_o), 64'd1);
    chk("oob.rd.rdata", bus2.cfg_rdata_o, 64'h0);
    bus2.cfg_we_i = 1; bus2.cfg_wdata_i = 64'hAB;
    tick();
    chk("oob.wr.err", 64'(bus2.cfg_err_o), 64'd1);
    bus2.cfg_we_i = 0; bus2.cfg_idx_i = 2'd2;
    tick();
    bus2.cfg_req_i = 0;
    chk("oob.r2.err",   64'(bus2.cfg_err_o), 64'd0);
    chk("oob.r2.rdata", bus2.cfg_rdata_o, 64'h55);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pma_region_table.md
Name: pma_region_table

Overview:
Runtime-programmable physical-memory-attribute table, replacing the static per-core region lists (non-idempotent / execute / cached base+length arrays) with one table of NrRules rules.
- Reset loads parameter values, so the default behaviour matches today's static map.
- Software then reprograms rules through a request/response config port; rules are individually lockable.
- Sits beside the MMU/PMP path. Serves registered, single-cycle lookups to fetch and LSU.

Parameters:
NrRules, 4, number of region rules (1..16)
AddrWidth, 64, physical address / base / length width
RstBase, '0, NrRules*AddrWidth packed reset base values, rule 0 in LSBs
RstLength, '0, NrRules*AddrWidth packed reset lengths; 0 = rule disabled
RstAttr, '0, NrRules*4 packed reset attributes {lock,cached,exec,nonidem}
DefaultAttr, 3'b000, {cached,exec,nonidem} returned on miss

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cfg_req_i  in  1  config request valid
cfg_gnt_o  out  1  config request accepted
cfg_we_i  in  1  1 = write, 0 = read
cfg_idx_i  in  $clog2(NrRules) (min 1)  rule index
cfg_field_i  in  2  field: 0 base, 1 length, 2 attr, 3 reserved
cfg_wdata_i  in  AddrWidth  write data; attr uses bits [3:0]
cfg_rvalid_o  out  1  response valid, exactly one per accepted request
cfg_rdata_o  out  AddrWidth  read data; 0 for writes/errors
cfg_err_o  out  1  response error
lkp_valid_i  in  1  lookup request
lkp_addr_i  in  AddrWidth  lookup address
lkp_valid_o  out  1  lookup result valid
lkp_hit_o  out  1  some enabled rule matched
lkp_idx_o  out  $clog2(NrRules) (min 1)  lowest matching rule index
lkp_attr_o  out  3  {cached,exec,nonidem}
lkp_multi_o  out  1  more than one rule matched

Behaviour:
- Reset (synchronous, rst_i high at clk_i edge):
  - Table is loaded from RstBase/RstLength/RstAttr.
  - All outputs are 0 except cfg_gnt_o.
  - Any pending response is dropped.
- Config port:
  - cfg_gnt_o = !rst_i, combinational. Every request presented outside reset is accepted.
  - Response comes in the next cycle: cfg_rvalid_o = 1 for exactly one cycle.
  - Back-to-back requests are supported, one response per cycle.
- Reads:
  - Return the current field, zero-extended; attr is in bits [3:0].
  - Reserved field or idx >= NrRules: cfg_err_o = 1, rdata = 0.
- Writes:
  - Updated at the accepting edge.
  - Rejected (err = 1, no update) if the rule's lock bit is set, the field is reserved, or idx >= NrRules.
  - An attr write with wdata[3] = 1 sets lock. Lock clears only on reset.
  - Writing attr to an unlocked rule is allowed even when it sets lock in the same write.
- Matching (per rule, combinational):
  - Rule is enabled when length != 0.
  - Match when base <= addr and addr < base + length, computed at AddrWidth+1 bits. No wrap: the end above 2^AddrWidth is the top of the space.
- Priority and outputs:
  - Lowest-index match wins. lkp_multi_o = popcount(match) > 1.
  - Miss: hit = 0, idx = 0, attr = DefaultAttr.
- Lookup latency is 1 cycle:
  - lkp_valid_o(t+1) = lkp_valid_i(t).
  - Result fields register only when lkp_valid_i; otherwise they hold.
- Simultaneous write and lookup in the same cycle: the lookup sees the pre-write table. The next cycle's lookup sees the new value.
- Reset asserted during a lookup: lkp_valid_o is 0 in the following cycle.
- No backpressure on either port.

Decomposition:
- Package pma_region_pkg holds:
  - enum cfg_field_e {FIELD_BASE, FIELD_LENGTH, FIELD_ATTR, FIELD_RSVD};
  - packed struct pma_attr_t {lock, cached, exec, nonidem};
  - localparam MaxRules = 16.
- Sub-module pma_region_match: one combinational comparator (base, length, addr -> match), instantiated NrRules times.
- Table registers, config FSM and priority encoder live in pma_region_table.

Test Plan:
- Reset check:
  - Parameters: rule 0 base 0x8000_0000, len 0x4000_0000, attr 4'b0110; NrRules 4.
  - After reset, lookup 0x8000_1000 -> next cycle valid = 1, hit = 1, idx = 0, attr = 3'b110, multi = 0.
  - Lookup 0xC000_0000 -> hit = 0, attr = DefaultAttr (exclusive end).
- Program rule 1:
  - Write base 0x1_0000, length 0x1_0000, attr 4'b0010; each write gets rvalid next cycle with err = 0.
  - Lookup 0x1_FFFF -> hit, idx 1, attr 3'b010.
  - Read back length -> rdata 0x1_0000.
- Lock:
  - Write attr 4'b1001 to rule 2 -> err = 0.
  - Then write base to rule 2 -> err = 1, readback unchanged.
  - Assert rst_i -> rule 2 is unlocked and back at its reset values.
- Overlap:
  - Rule 1 covers 0x8000_0000..0x8000_FFFF with attr 4'b0001, overlapping rule 0.
  - Lookup 0x8000_0010 -> idx 0, multi = 1, attr 3'b110.
- Top-of-space:
  - Rule 3 base 0xFFFF_FFFF_FFFF_F000, len 0x2000.
  - Lookup 0xFFFF_FFFF_FFFF_FFFF -> hit idx 3.
  - Lookup 0x0 -> rule 3 does not match.
- Same-cycle and error cases:
  - Write base of rule 1 to 0x0 while looking up 0x1_0000 in the same cycle -> old result (hit idx 1).
  - Repeat the lookup next cycle -> reflects the new value.
  - cfg_field_i = 3, or idx >= NrRules -> err = 1, rdata = 0.
